// File: rtl/fe_mul_pkg.sv
// Shared widths, constants and types for the GF(2^255-19) multiplier.
package fe_pkg;
  localparam int LIMB_W = 17;
  localparam int NLIMBS = 15;
  localparam int MID_W  = 44;
  localparam int FOLD   = 19;
  localparam int FE_W   = LIMB_W * NLIMBS;
  localparam logic [FE_W-1:0] P = {{(FE_W-5){1'b1}}, 5'b01101};

  typedef logic [LIMB_W-1:0]              limb_t;
  typedef logic [MID_W-1:0]               mid_t;
  typedef logic [NLIMBS-1:0][LIMB_W-1:0]  limbs_t;
  typedef logic [NLIMBS-1:0][MID_W-1:0]   mids_t;
  typedef enum logic [2:0] {IDLE, MUL, RED, FIN, DONE} state_t;

  // Limbs 1..14 are 17-bit after reduction; limb 0 may carry a few extra bits.
  function automatic logic [FE_W-1:0] pack_mid(input mids_t m);
    logic [FE_W-1:0] v;
    v = '0;
    for (int i = 1; i < NLIMBS; i++) v[i*LIMB_W +: LIMB_W] = m[i][LIMB_W-1:0];
    return v + FE_W'(m[0]);
  endfunction
endpackage

// File: rtl/fe_mul_if.sv
// Start/operand/result bundle for fe_mul.
interface fe_mul_if;
  logic                   start;
  logic [fe_pkg::FE_W-1:0] a;
  logic [fe_pkg::FE_W-1:0] b;
  logic                   done;
  logic [fe_pkg::FE_W-1:0] out;

  modport master (output start, a, b, input done, out);
  modport slave  (input start, a, b, output done, out);
endinterface

// File: rtl/fe_mul_row.sv
// One a-limb times all b-limbs, emitted per destination column with the x19 wrap fold.
module fe_mul_row
  import fe_pkg::*;
(
  input  limb_t        a_limb,
  input  logic [3:0]   row,
  input  limbs_t       b_limbs,
  output mids_t        col_prod
);
  for (genvar c = 0; c < NLIMBS; c++) begin : g_col
    logic                wrap;
    logic [3:0]          jidx;
    logic [2*LIMB_W-1:0] prod;
    // Column c receives b[j] with i+j == c, or i+j == c+15 when it wrapped (c < i).
    assign wrap = 4'(c) < row;
    assign jidx = 4'(c) - row + (wrap ? 4'(NLIMBS) : 4'd0);
    assign prod = (2*LIMB_W)'(a_limb) * (2*LIMB_W)'(b_limbs[jidx]);
    assign col_prod[c] = wrap ? MID_W'(prod) * MID_W'(FOLD) : MID_W'(prod);
  end
endmodule

// File: rtl/fe_mul.sv
// Multi-cycle a*b mod 2^255-19: column MAC, two carry passes, optional final subtract.
// Define FE_MUL_FINAL_REDUCE_EN for a canonical result (adds the FIN cycle).
module fe_mul
  import fe_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  fe_mul_if.slave   bus
);
  localparam logic [4:0] RED_LAST = 5'(2*NLIMBS);

  state_t          state_q, state_d;
  logic [3:0]      multiply_step_q, multiply_step_d;
  logic [4:0]      reduce_step_q, reduce_step_d;
  mid_t            carry_q, carry_d;
  mids_t           mid_q, mid_d;
  limbs_t          a_q, a_d, b_q, b_d;
  logic [FE_W-1:0] out_q, out_d;
  logic            done_q, done_d;
  mids_t           row_prod;

  logic [3:0]      n;
  mid_t            t, c;
  logic [FE_W-1:0] v;

  fe_mul_row u_row (
    .a_limb   (a_q[multiply_step_q]),
    .row      (multiply_step_q),
    .b_limbs  (b_q),
    .col_prod (row_prod)
  );

  always_comb begin
    state_d         = state_q;
    multiply_step_d = multiply_step_q;
    reduce_step_d   = reduce_step_q;
    carry_d         = carry_q;
    mid_d           = mid_q;
    a_d             = a_q;
    b_d             = b_q;
    out_d           = out_q;
    done_d          = done_q;
    n               = '0;
    t               = '0;
    c               = '0;
    v               = '0;

    case (state_q)
      MUL: begin
        for (int k = 0; k < NLIMBS; k++) mid_d[k] = mid_q[k] + row_prod[k];
        if (multiply_step_q == 4'(NLIMBS-1)) begin
          state_d       = RED;
          reduce_step_d = '0;
        end else begin
          multiply_step_d = multiply_step_q + 4'd1;
        end
      end
      RED: begin
        if (reduce_step_q == RED_LAST) begin
          mid_d[0] = mid_q[0] + carry_q;
          carry_d  = '0;
`ifdef FE_MUL_FINAL_REDUCE_EN
          state_d  = FIN;
`else
          out_d    = pack_mid(mid_d);
          state_d  = DONE;
`endif
        end else begin
          n = (reduce_step_q < 5'(NLIMBS)) ? reduce_step_q[3:0]
                                           : 4'(reduce_step_q - 5'(NLIMBS));
          t = mid_q[n] + carry_q;
          mid_d[n] = MID_W'(t[LIMB_W-1:0]);
          c = t >> LIMB_W;
          // Carry out of limb 14 has weight 2^255, which is 19 mod p.
          carry_d = (n == 4'(NLIMBS-1)) ? c * MID_W'(FOLD) : c;
          reduce_step_d = reduce_step_q + 5'd1;
        end
      end
      FIN: begin
        v       = pack_mid(mid_q);
        out_d   = (v >= P) ? v - P : v;
        state_d = DONE;
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase

    // A start pulse always wins, restarting whatever was in flight.
    if (bus.start) begin
      a_d             = bus.a;
      b_d             = bus.b;
      mid_d           = '0;
      carry_d         = '0;
      multiply_step_d = '0;
      reduce_step_d   = '0;
      done_d          = 1'b0;
      state_d         = MUL;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      multiply_step_q <= '0;
      reduce_step_q   <= '0;
      carry_q         <= '0;
      mid_q           <= '0;
      a_q             <= '0;
      b_q             <= '0;
      out_q           <= '0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      multiply_step_q <= multiply_step_d;
      reduce_step_q   <= reduce_step_d;
      carry_q         <= carry_d;
      mid_q           <= mid_d;
      a_q             <= a_d;
      b_q             <= b_d;
      out_q           <= out_d;
      done_q          <= done_d;
    end
  end

  assign bus.done = done_q;
  assign bus.out  = out_q;
endmodule

// File: tb/tb_fe_mul.sv
// Scoreboard bench for fe_mul: reference a*b mod p queued at launch, checked at done.
module tb_fe_mul;
  import fe_pkg::*;

`ifdef FE_MUL_FINAL_REDUCE_EN
  localparam int LAT = 48;
`else
  localparam int LAT = 47;
`endif
  localparam int BUDGET = 200;

  logic clock = 1'b0;
  logic reset = 1'b1;
  fe_mul_if bus();

  fe_mul u_dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;
  logic [FE_W-1:0] exp_q[$];

  function automatic logic [FE_W-1:0] ref_mul(input logic [FE_W-1:0] x, input logic [FE_W-1:0] y);
    logic [511:0] pr;
    pr = {257'b0, x} * {257'b0, y};
    pr = pr % {257'b0, P};
    return pr[FE_W-1:0];
  endfunction

  // Without the final subtract the result may legally be r+p; fold it before comparing.
  function automatic logic [FE_W-1:0] canon(input logic [FE_W-1:0] x);
`ifdef FE_MUL_FINAL_REDUCE_EN
    return x;
`else
    return (x >= P) ? x - P : x;
`endif
  endfunction

  function automatic logic [FE_W-1:0] rand_fe();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r[FE_W-1:0];
  endfunction

  task automatic launch(input logic [FE_W-1:0] x, input logic [FE_W-1:0] y, input bit push);
    @(negedge clock);
    bus.start = 1'b1;
    bus.a     = x;
    bus.b     = y;
    if (push) exp_q.push_back(ref_mul(x, y));
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  // Returns edges from the start edge to the first edge with done high (BUDGET+1 on timeout).
  task automatic wait_done(output int lat);
    lat = 0;
    while (lat <= BUDGET) begin
      @(negedge clock);
      lat++;
      if (bus.done) break;
    end
  endtask

  task automatic test_reset;
    bit seen;
    seen = 0;
    reset = 1'b1;
    bus.start = 1'b1;
    bus.a = 255'd2;
    bus.b = 255'd3;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    bus.start = 1'b0;
    n_vec++;
    if (bus.out !== '0) begin
      n_bad++;
      $display("FAIL reset_out got=%h exp=0", bus.out);
    end
    repeat (60) begin
      @(negedge clock);
      if (bus.done !== 1'b0) seen = 1;
    end
    n_vec++;
    if (seen) begin
      n_bad++;
      $display("FAIL reset_beats_start done rose got=1 exp=0");
    end
  endtask

  task automatic test_vectors;
    logic [FE_W-1:0] ta[6], tb[6], te[6];
    logic [FE_W-1:0] got, exp_v;
    int lat;
    ta[0] = 255'd2;      tb[0] = 255'd3;      te[0] = 255'd6;
    ta[1] = P - 255'd1;  tb[1] = P - 255'd1;  te[1] = 255'd1;
    ta[2] = 255'd1 << 254; tb[2] = 255'd2;    te[2] = 255'd19;
    ta[3] = P;           tb[3] = 255'd1;      te[3] = 255'd0;
    ta[4] = '1;          tb[4] = 255'd1;      te[4] = 255'd18;
    ta[5] = '1;          tb[5] = '1;          te[5] = 255'd324;
    for (int i = 0; i < 6; i++) begin
      launch(ta[i], tb[i], 1'b1);
      wait_done(lat);
      n_vec++;
      if (lat !== LAT) begin
        n_bad++;
        $display("FAIL vec%0d_latency got=%0d exp=%0d", i, lat, LAT);
      end
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      got = canon(bus.out);
      n_vec++;
      if (got !== te[i] || exp_v !== te[i]) begin
        n_bad++;
        $display("FAIL vec%0d_out got=%h exp=%h", i, got, te[i]);
      end
    end
  endtask

  task automatic test_abort;
    bit seen;
    int lat;
    logic [FE_W-1:0] exp_v;
    seen = 0;
    launch(255'd5, 255'd7, 1'b0);
    repeat (18) begin
      @(negedge clock);
      if (bus.done !== 1'b0) seen = 1;
    end
    // Start edge of the re-pulse is 20 edges after the first.
    launch(255'd4, 255'd4, 1'b1);
    if (bus.done !== 1'b0) seen = 1;
    n_vec++;
    if (seen) begin
      n_bad++;
      $display("FAIL abort_done_low got=1 exp=0");
    end
    wait_done(lat);
    n_vec++;
    if (lat !== LAT) begin
      n_bad++;
      $display("FAIL abort_latency got=%0d exp=%0d", lat, LAT);
    end
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_vec++;
    if (canon(bus.out) !== 255'd16 || exp_v !== 255'd16) begin
      n_bad++;
      $display("FAIL abort_out got=%h exp=%h", canon(bus.out), 255'd16);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [FE_W-1:0] exp_v;
    launch(255'd7, 255'd9, 1'b0);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_vec++;
    if (bus.done !== 1'b0 || bus.out !== '0) begin
      n_bad++;
      $display("FAIL reset_mid got done=%b out=%h exp done=0 out=0", bus.done, bus.out);
    end
    launch(255'd3, 255'd3, 1'b1);
    wait_done(lat);
    n_vec++;
    if (lat !== LAT) begin
      n_bad++;
      $display("FAIL reset_mid_latency got=%0d exp=%0d", lat, LAT);
    end
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_vec++;
    if (canon(bus.out) !== 255'd9 || exp_v !== 255'd9) begin
      n_bad++;
      $display("FAIL reset_mid_out got=%h exp=%h", canon(bus.out), 255'd9);
    end
  endtask

  task automatic test_random;
    int lat;
    logic [FE_W-1:0] x, y, exp_v;
    for (int i = 0; i < 12; i++) begin
      x = rand_fe();
      y = rand_fe();
      launch(x, y, 1'b1);
      wait_done(lat);
      n_vec++;
      if (lat !== LAT) begin
        n_bad++;
        $display("FAIL rand%0d_latency got=%0d exp=%0d", i, lat, LAT);
      end
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_vec++;
      if (canon(bus.out) !== exp_v) begin
        n_bad++;
        $display("FAIL rand%0d_out got=%h exp=%h", i, canon(bus.out), exp_v);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    test_reset;
    test_vectors;
    test_abort;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
